pwm_reg_arbiter: RTL and testbench
==================================

PWM_REG_ARBITER -- requirements
Module: pwm_reg_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the register data width.
REQ-002 The block SHALL have parameter AW, default 8, meaning the register address width.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m0_req  input  1  requester 0 (I2C slave side) transaction request, level.
REQ-006 m0_we  input  1  requester 0: 1 = write, 0 = read.
REQ-007 m0_addr  input  AW  requester 0 register address.
REQ-008 m0_wdata  input  WIDTH  requester 0 write data.
REQ-009 m0_ack  output  1  requester 0 completion pulse, one cycle.
REQ-010 m0_rdata  output  WIDTH  requester 0 read data, valid when m0_ack is high after a read.
REQ-011 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata SHALL be identical to REQ-005 to REQ-010 for requester 1 (internal sequencer).
REQ-012 reg_addr_o  output  AW  shared register-file address.
REQ-013 reg_wdata_o  output  WIDTH  shared register-file write data.
REQ-014 reg_write_o  output  1  register write strobe, one cycle.
REQ-015 reg_read_o  output  1  register read strobe, one cycle.
REQ-016 reg_rdata_i  input  WIDTH  register read data, valid the cycle after reg_read_o.
REQ-017 busy_o  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, CAPT and ACK.
REQ-019 In IDLE with any req high, the block SHALL pick a winner, latch its we/addr/wdata and index, and move to ISSUE; otherwise it stays in IDLE.
REQ-020 In ISSUE, the block SHALL drive reg_addr_o and reg_wdata_o from the latched values and pulse reg_write_o (if we=1) or reg_read_o (if we=0) for exactly one cycle, then go to ACK on a write or CAPT on a read.
REQ-021 In CAPT, the block SHALL latch reg_rdata_i into the winner's mX_rdata and go to ACK.
REQ-022 In ACK, the block SHALL pulse the winner's mX_ack for one cycle and return to IDLE.
REQ-023 Latency: with req sampled in IDLE at cycle T, write ack SHALL occur at T+2 and read ack at T+3; back-to-back grants SHALL have one IDLE cycle between them.
REQ-024 Requesters SHALL hold req and their fields stable until ack; req still high on the cycle after ack SHALL be treated as a new request.
REQ-025 A req dropped before the IDLE sampling edge SHALL be ignored; a req dropped after latching SHALL not abort the transaction, which completes and acks.
REQ-026 mX_rdata SHALL hold its value until the next read completes for that requester; writes SHALL leave it unchanged.
REQ-027 Default arbitration SHALL be 2-way round-robin: on simultaneous requests, grant the requester not granted last; a single request is granted immediately regardless of the pointer.
REQ-028 reg_addr_o and reg_wdata_o SHALL keep the last issued values outside ISSUE; strobes SHALL be 0 outside ISSUE.

Reset
REQ-029 On rst, the block SHALL go to IDLE, set all strobes, acks and busy_o to 0, set mX_rdata, reg_addr_o and reg_wdata_o to 0, and set the round-robin pointer so requester 0 wins the first tie.
REQ-030 On rst asserted mid-transaction, the block SHALL drop the transaction with no strobe and no ack afterwards.

Configuration
REQ-031 With PWM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties (fixed priority) and the round-robin pointer SHALL be omitted; without it, round-robin per REQ-027 applies.

Structure
REQ-032 Package pwm_arb_pkg SHALL hold the FSM state enum, requester-index constants (REQ_M0=0, REQ_M1=1) and default WIDTH/AW constants.
REQ-033 The winner selection SHALL be sub-module rr_arb2 (inputs: two requests and the last grant; output: grant index), with the fixed-priority variant selected by the macro.

Verification
REQ-034 m0 write addr 0x10, data 0x1234 alone -> reg_write_o pulse at T+1 with addr 0x10/data 0x1234; m0_ack at T+2.
REQ-035 m1 read addr 0x05, reg_rdata_i=0xBEEF at the cycle after reg_read_o -> m1_rdata=0xBEEF with m1_ack at T+3.
REQ-036 Both req held continuously after reset -> grants alternate m0,m1,m0,m1 (round-robin); with PWM_ARB_FIXED_PRIO_EN -> m0 every time.
REQ-037 rst asserted during CAPT of a read -> next cycle IDLE, no ack, m0_rdata=0, busy_o=0.
REQ-038 m0_req pulsed one cycle in IDLE then dropped -> transaction still issues and m0_ack pulses; req low while busy otherwise -> no extra grant.

Source files
------------

// File: rtl/pwm_arb_pkg.sv
// Shared types and constants for the PWM register-file arbiter.
// The FSM state enum, requester indices and default data/address widths.
package pwm_arb_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AW    = 8;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_ACK   = 2'd3
  } pwm_arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner selection for the register arbiter.
// Round-robin by default; with PWM_ARB_FIXED_PRIO_EN requester 0 wins every tie.
module rr_arb2
  import pwm_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic grant_o
);

`ifdef PWM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    grant_o = REQ_M0;
    if (!req0_i && req1_i) grant_o = REQ_M1;
  end
`else
  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant_o = REQ_M0;
    if (req0_i && req1_i) begin
      grant_o = (last_i == REQ_M0) ? REQ_M1 : REQ_M0;
    end else if (req1_i) begin
      grant_o = REQ_M1;
    end
  end
`endif

endmodule

// File: rtl/pwm_reg_arbiter.sv
// Arbitrates the I2C-slave side (m0) and the internal sequencer (m1) onto one register file.
// Build option: PWM_ARB_FIXED_PRIO_EN selects fixed priority (m0 wins ties) instead of round-robin.
//
// Handshake: a requester raises mX_req with stable we/addr/wdata and holds them until mX_ack;
// the request is latched on the IDLE sampling edge, after which dropping req does not abort it.
// mX_ack is a one-cycle pulse; mX_rdata is valid with the ack of a read and holds until the next read.
module pwm_reg_arbiter
  import pwm_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [AW-1:0]    m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_ack,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [AW-1:0]    m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_ack,
  output logic [WIDTH-1:0] m1_rdata,
  output logic [AW-1:0]    reg_addr_o,
  output logic [WIDTH-1:0] reg_wdata_o,
  output logic             reg_write_o,
  output logic             reg_read_o,
  input  logic [WIDTH-1:0] reg_rdata_i,
  output logic             busy_o,
  output pwm_arb_state_e   state_o
);

  pwm_arb_state_e   state_q;
  logic             win_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             write_q;
  logic             read_q;
  logic             ack0_q;
  logic             ack1_q;
  logic [WIDTH-1:0] rdata0_q;
  logic [WIDTH-1:0] rdata1_q;

  logic             grant;
  logic             last_sel;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;

`ifdef PWM_ARB_FIXED_PRIO_EN
  assign last_sel = REQ_M1;
`else
  logic last_q;
  assign last_sel = last_q;

  // Reset to m1 so that m0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_M1;
    end else if (state_q == ST_IDLE && (m0_req || m1_req)) begin
      last_q <= grant;
    end
  end
`endif

  rr_arb2 u_arb (
    .req0_i (m0_req),
    .req1_i (m1_req),
    .last_i (last_sel),
    .grant_o(grant)
  );

  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (grant == REQ_M1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Strobes and acks default low each cycle so they can only ever be single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      win_q    <= REQ_M0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            state_q <= ST_ISSUE;
            win_q   <= grant;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            write_q <= sel_we;
            read_q  <= !sel_we;
          end
        end
        ST_ISSUE: begin
          if (write_q) begin
            state_q <= ST_ACK;
            ack0_q  <= (win_q == REQ_M0);
            ack1_q  <= (win_q == REQ_M1);
          end else begin
            state_q <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (win_q == REQ_M0) rdata0_q <= reg_rdata_i;
          else                 rdata1_q <= reg_rdata_i;
          state_q <= ST_ACK;
          ack0_q  <= (win_q == REQ_M0);
          ack1_q  <= (win_q == REQ_M1);
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_write_o = write_q;
  assign reg_read_o  = read_q;
  assign m0_ack      = ack0_q;
  assign m1_ack      = ack1_q;
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Self-checking bench for pwm_reg_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of grants, latencies and read data.
module tb_pwm_reg_arbiter;
  import pwm_arb_pkg::*;

  localparam int W  = 16;
  localparam int AW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           m0_req, m0_we, m0_ack;
  logic [AW-1:0]  m0_addr;
  logic [W-1:0]   m0_wdata, m0_rdata;
  logic           m1_req, m1_we, m1_ack;
  logic [AW-1:0]  m1_addr;
  logic [W-1:0]   m1_wdata, m1_rdata;
  logic [AW-1:0]  reg_addr_o;
  logic [W-1:0]   reg_wdata_o;
  logic           reg_write_o, reg_read_o;
  logic [W-1:0]   reg_rdata_i;
  logic           busy_o;
  pwm_arb_state_e state_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pwm_reg_arbiter #(.WIDTH(W), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_write_o(reg_write_o), .reg_read_o(reg_read_o),
    .reg_rdata_i(reg_rdata_i), .busy_o(busy_o), .state_o(state_o)
  );

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    reg_rdata_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, reg_write_o, reg_read_o, m0_ack, m1_ack} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {busy_o, reg_write_o, reg_read_o, m0_ack, m1_ack});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata);
    end
    checks++;
    if ({reg_addr_o, reg_wdata_o} !== 24'h0) begin
      errors++; $display("FAIL reset_bus got addr=%h data=%h exp=0/0", reg_addr_o, reg_wdata_o);
    end
    checks++;
    if (state_o !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got=%0d exp=%0d", state_o, ST_IDLE);
    end
    rst = 1'b0;
  endtask

  // m0 write 0x10 <- 0x1234 alone: strobe at T+1, ack at T+2
  task automatic test_write_single();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if ({reg_write_o, reg_read_o, busy_o, m0_ack} !== 4'b1010) begin
      errors++; $display("FAIL wr_issue got=%b exp=1010", {reg_write_o, reg_read_o, busy_o, m0_ack});
    end
    checks++;
    if ({reg_addr_o, reg_wdata_o} !== {8'h10, 16'h1234}) begin
      errors++; $display("FAIL wr_bus got addr=%h data=%h exp=10/1234", reg_addr_o, reg_wdata_o);
    end
    @(negedge clk);
    checks++;
    if ({reg_write_o, reg_read_o, m0_ack, m1_ack, busy_o} !== 5'b00101) begin
      errors++; $display("FAIL wr_ack got=%b exp=00101", {reg_write_o, reg_read_o, m0_ack, m1_ack, busy_o});
    end
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, m0_ack, reg_write_o} !== 3'b000) begin
      errors++; $display("FAIL wr_after got=%b exp=000", {busy_o, m0_ack, reg_write_o});
    end
    checks++;
    if (reg_addr_o !== 8'h10 || m0_rdata !== 16'h0) begin
      errors++; $display("FAIL wr_hold got addr=%h rdata=%h exp=10/0000", reg_addr_o, m0_rdata);
    end
  endtask

  // m1 read 0x05, register answers 0xBEEF the cycle after the strobe
  task automatic test_read_single();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h05; m1_wdata = 16'h0F0F;
    reg_rdata_i = 16'hDEAD;
    @(negedge clk);
    checks++;
    if ({reg_read_o, reg_write_o, reg_addr_o} !== {2'b10, 8'h05}) begin
      errors++; $display("FAIL rd_issue got rd=%b wr=%b addr=%h exp=1/0/05", reg_read_o, reg_write_o, reg_addr_o);
    end
    @(negedge clk);
    checks++;
    if ({reg_read_o, reg_write_o, m1_ack, busy_o} !== 4'b0001) begin
      errors++; $display("FAIL rd_capt got=%b exp=0001", {reg_read_o, reg_write_o, m1_ack, busy_o});
    end
    reg_rdata_i = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({m1_ack, m0_ack} !== 2'b10 || m1_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL rd_ack got ack=%b rdata=%h exp=10/beef", {m1_ack, m0_ack}, m1_rdata);
    end
    checks++;
    if (m0_rdata !== 16'h0) begin
      errors++; $display("FAIL rd_other got=%h exp=0000", m0_rdata);
    end
    reg_rdata_i = 16'hDEAD;
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_ack, busy_o} !== 2'b00 || m1_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL rd_hold got ack=%b busy=%b rdata=%h exp=0/0/beef", m1_ack, busy_o, m1_rdata);
    end
  endtask

  // reset during CAPT drops the read entirely
  task automatic test_reset_mid_capt();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h40; m0_wdata = 16'h0;
    reg_rdata_i = 16'hAAAA;
    @(negedge clk);
    checks++;
    if (reg_read_o !== 1'b1) begin
      errors++; $display("FAIL rc_issue got=%b exp=1", reg_read_o);
    end
    @(negedge clk);
    checks++;
    if (state_o !== ST_CAPT) begin
      errors++; $display("FAIL rc_state got=%0d exp=%0d", state_o, ST_CAPT);
    end
    rst = 1'b1;
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, m0_ack, m1_ack} !== 3'b000 || state_o !== ST_IDLE) begin
      errors++; $display("FAIL rc_reset got=%b state=%0d exp=000/0", {busy_o, m0_ack, m1_ack}, state_o);
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 32'h0) begin
      errors++; $display("FAIL rc_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({m0_ack, m1_ack, reg_write_o, reg_read_o, busy_o} !== 5'b0) begin
        errors++; $display("FAIL rc_quiet got=%b exp=00000", {m0_ack, m1_ack, reg_write_o, reg_read_o, busy_o});
      end
    end
  endtask

  // both requesters held after reset: alternate (or m0 always with fixed priority)
  task automatic test_round_robin();
    int n;
    logic exp_who;
    logic [AW-1:0] ea;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h20; m0_wdata = 16'hA0A0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h21; m1_wdata = 16'hB1B1;
    n = 0;
    for (int k = 1; k <= 20 && n < 4; k++) begin
      @(negedge clk);
      if (reg_write_o === 1'b1) begin
`ifdef PWM_ARB_FIXED_PRIO_EN
        exp_who = 1'b0;
`else
        exp_who = (n % 2 == 1);
`endif
        ea = exp_who ? 8'h21 : 8'h20;
        checks++;
        if (reg_addr_o !== ea) begin
          errors++; $display("FAIL rr_grant%0d got addr=%h exp=%h", n, reg_addr_o, ea);
        end
        checks++;
        if (k != 1 + 3 * n) begin
          errors++; $display("FAIL rr_timing%0d got cycle=%0d exp=%0d", n, k, 1 + 3 * n);
        end
        n++;
        if (n == 4) begin
          m0_req = 1'b0; m1_req = 1'b0;
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL rr_count got=%0d exp=4", n);
      m0_req = 1'b0; m1_req = 1'b0;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL rr_drain got busy=%b exp=0", busy_o);
    end
  endtask

  // single-cycle req pulse still completes; no extra grant afterwards
  task automatic test_pulse_req();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h30; m0_wdata = 16'h5555;
    @(negedge clk);
    checks++;
    if ({reg_write_o, reg_addr_o, reg_wdata_o} !== {1'b1, 8'h30, 16'h5555}) begin
      errors++; $display("FAIL pulse_issue got wr=%b addr=%h data=%h exp=1/30/5555", reg_write_o, reg_addr_o, reg_wdata_o);
    end
    m0_req = 1'b0; m0_addr = 8'h77; m0_wdata = 16'h0;
    @(negedge clk);
    checks++;
    if ({m0_ack, m1_ack} !== 2'b10) begin
      errors++; $display("FAIL pulse_ack got=%b exp=10", {m0_ack, m1_ack});
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({reg_write_o, reg_read_o, m0_ack, m1_ack, busy_o} !== 5'b0) begin
        errors++; $display("FAIL pulse_quiet got=%b exp=00000", {reg_write_o, reg_read_o, m0_ack, m1_ack, busy_o});
      end
    end
  endtask

  // randomized traffic against a transaction-level model
  task automatic test_random();
    int issue_c, ack_c;
    bit active, exp_busy;
    logic who, twe, last_win;
    logic [AW-1:0] taddr;
    logic [W-1:0] twdata;
    logic [W-1:0] exp_rd[2];
    int ast[2];
    logic a_req[2], a_we[2];
    logic [AW-1:0] a_addr[2];
    logic [W-1:0] a_wdata[2];

    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    active = 1'b0; issue_c = -10; ack_c = -10; who = 1'b0; twe = 1'b0;
    taddr = '0; twdata = '0; last_win = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      ast[i] = 0; a_req[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = '0;
    end

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      exp_busy = active;
      checks++;
      if (busy_o !== exp_busy) begin
        errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy_o, exp_busy);
      end
      checks++;
      if ({reg_write_o, reg_read_o} !== {active && c == issue_c && twe, active && c == issue_c && !twe}) begin
        errors++; $display("FAIL rnd_strobe c=%0d got=%b%b exp=%b%b", c, reg_write_o, reg_read_o,
                           active && c == issue_c && twe, active && c == issue_c && !twe);
      end
      if (active && c == issue_c) begin
        checks++;
        if ({reg_addr_o, reg_wdata_o} !== {taddr, twdata}) begin
          errors++; $display("FAIL rnd_bus c=%0d got %h/%h exp %h/%h", c, reg_addr_o, reg_wdata_o, taddr, twdata);
        end
      end
      checks++;
      if ({m0_ack, m1_ack} !== {active && c == ack_c && !who, active && c == ack_c && who}) begin
        errors++; $display("FAIL rnd_ack c=%0d got=%b%b exp=%b%b", c, m0_ack, m1_ack,
                           active && c == ack_c && !who, active && c == ack_c && who);
      end
      if (active && c == ack_c && !twe) exp_rd[who] = exp_q.pop_front();
      checks++;
      if (m0_rdata !== exp_rd[0]) begin
        errors++; $display("FAIL rnd_rdata0 c=%0d got=%h exp=%h", c, m0_rdata, exp_rd[0]);
      end
      checks++;
      if (m1_rdata !== exp_rd[1]) begin
        errors++; $display("FAIL rnd_rdata1 c=%0d got=%h exp=%h", c, m1_rdata, exp_rd[1]);
      end

      // register file answers with fresh random data every cycle
      reg_rdata_i = W'($urandom);
      if (active && !twe && c == issue_c + 1) exp_q.push_back(reg_rdata_i);
      if (active && c == ack_c) begin
        active = 1'b0;
        ast[who] = 0;
      end

      for (int i = 0; i < 2; i++) begin
        case (ast[i])
          0: begin
            if ($urandom_range(0, 2) == 0) begin
              ast[i] = 1; a_req[i] = 1'b1; a_we[i] = 1'($urandom);
              a_addr[i] = AW'($urandom); a_wdata[i] = W'($urandom);
            end else begin
              a_req[i] = 1'b0;
            end
          end
          1: begin
            if ($urandom_range(0, 9) == 0) begin
              ast[i] = 0; a_req[i] = 1'b0;
            end
          end
          default: a_req[i] = 1'($urandom_range(0, 1));
        endcase
      end
      m0_req = a_req[0]; m0_we = a_we[0]; m0_addr = a_addr[0]; m0_wdata = a_wdata[0];
      m1_req = a_req[1]; m1_we = a_we[1]; m1_addr = a_addr[1]; m1_wdata = a_wdata[1];

      if (!exp_busy && (a_req[0] || a_req[1])) begin
        if (a_req[0] && a_req[1]) begin
`ifdef PWM_ARB_FIXED_PRIO_EN
          who = 1'b0;
`else
          who = !last_win;
`endif
        end else begin
          who = a_req[1];
        end
        last_win = who;
        twe = a_we[who]; taddr = a_addr[who]; twdata = a_wdata[who];
        active = 1'b1;
        issue_c = c + 1;
        ack_c = twe ? c + 2 : c + 3;
        ast[who] = 2;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_single();
    test_reset_mid_capt();
    test_round_robin();
    test_pulse_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
